// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution window sequencer.
package conv_ctrl_pkg;

    localparam int FILTERSIZE = 9;
    localparam int KDIM       = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETTLE = 3'd2,
        RELU   = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0] TAP_FIRST       = 4'd0;
    localparam logic [3:0] TAP_REUSE_FIRST = 4'd2;
    localparam logic [3:0] TAP_LAST        = 4'd8;

    function automatic logic [1:0] tap_row(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: tap_row = 2'd0;
            4'd3, 4'd4, 4'd5: tap_row = 2'd1;
            4'd6, 4'd7, 4'd8: tap_row = 2'd2;
            default:          tap_row = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tap_col(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: tap_col = 2'd0;
            4'd1, 4'd4, 4'd7: tap_col = 2'd1;
            4'd2, 4'd5, 4'd8: tap_col = 2'd2;
            default:          tap_col = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window position counters and next-cycle read address / output index.
// CONV_REUSE_EN selects the first tap fetched for windows with wc>0.
module conv_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10,
    parameter int OIDX_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [3:0]        tap_nxt,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic [OIDX_W-1:0] idx_nxt,
    output logic [3:0]        first_tap,
    output logic              last_win
);
    import conv_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] WC_MAX    = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] WR_MAX    = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);
    localparam logic [OIDX_W-1:0] IDX_STEP  = OIDX_W'(IMG_W - 2);

    logic [ADDR_W-1:0] wr_r, wc_r, row_base_r;
    logic [OIDX_W-1:0] out_base_r;
    logic [ADDR_W-1:0] wr_s, wc_s, row_base_s, row_off_s;
    logic [OIDX_W-1:0] out_base_s;

    // Next window position; row bases step by constants instead of multiplying.
    always_comb begin
        wr_s       = wr_r;
        wc_s       = wc_r;
        row_base_s = row_base_r;
        out_base_s = out_base_r;
        if (clr) begin
            wr_s       = {ADDR_W{1'b0}};
            wc_s       = {ADDR_W{1'b0}};
            row_base_s = {ADDR_W{1'b0}};
            out_base_s = {OIDX_W{1'b0}};
        end else if (adv) begin
            if (wc_r == WC_MAX) begin
                wc_s       = {ADDR_W{1'b0}};
                wr_s       = wr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                row_base_s = row_base_r + ROW_STEP;
                out_base_s = out_base_r + IDX_STEP;
            end else begin
                wc_s = wc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wr_s = wr_r;
        end

        case (tap_row(tap_nxt))
            2'd0:    row_off_s = {ADDR_W{1'b0}};
            2'd1:    row_off_s = ROW_STEP;
            2'd2:    row_off_s = ROW_STEP2;
            default: row_off_s = {ADDR_W{1'b0}};
        endcase

`ifdef CONV_REUSE_EN
        first_tap = (wc_s != {ADDR_W{1'b0}}) ? TAP_REUSE_FIRST : TAP_FIRST;
`else
        first_tap = TAP_FIRST;
`endif
    end

    assign addr_nxt = row_base_s + row_off_s + wc_s + {{(ADDR_W-2){1'b0}}, tap_col(tap_nxt)};
    assign idx_nxt  = out_base_s + OIDX_W'(wc_s);
    assign last_win = (wr_r == WR_MAX) && (wc_r == WC_MAX);

    // Window position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r       <= {ADDR_W{1'b0}};
            wc_r       <= {ADDR_W{1'b0}};
            row_base_r <= {ADDR_W{1'b0}};
            out_base_r <= {OIDX_W{1'b0}};
        end else begin
            wr_r       <= wr_s;
            wc_r       <= wc_s;
            row_base_r <= row_base_s;
            out_base_r <= out_base_s;
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer that walks the feature map, gathers 3x3 windows for conv and streams results.
// Optional column reuse (shift window, fetch taps 2/5/8 only) under CONV_REUSE_EN.
module conv_window_ctrl #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int FILTERSIZE = 9,
    parameter int ADDR_W     = 10,
    parameter int OIDX_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [7:0]              rd_data,
    output logic [8*FILTERSIZE-1:0] ifmap_o,
    input  logic [7:0]              ofmap_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [OIDX_W-1:0]       out_idx
);
    import conv_ctrl_pkg::*;

    state_t            state_r;
    logic [3:0]        tap_r, cap_k_r, tap_nxt_s, first_tap_s;
    logic              cap_v_r;
    logic [7:0]        win_r [FILTERSIZE];
    logic              hs_s, clr_s, adv_s, last_win_s;
    logic [ADDR_W-1:0] addr_nxt_s, rd_addr_r;
    logic [OIDX_W-1:0] idx_nxt_s, out_idx_r;
    logic              rd_en_r, busy_r, done_r, out_valid_r;
`ifdef CONV_REUSE_EN
    logic              partial_r;
`endif

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .OIDX_W (OIDX_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr_s),
        .adv       (adv_s),
        .tap_nxt   (tap_nxt_s),
        .addr_nxt  (addr_nxt_s),
        .idx_nxt   (idx_nxt_s),
        .first_tap (first_tap_s),
        .last_win  (last_win_s)
    );

    // Handshake, counter control and the tap to issue on the next cycle.
    always_comb begin
        hs_s  = (state_r == EMIT) && out_valid_r && out_ready;
        clr_s = (state_r == IDLE) && start;
        adv_s = hs_s && !last_win_s;
        if (state_r == FETCH) begin
`ifdef CONV_REUSE_EN
            tap_nxt_s = partial_r ? (tap_r + 4'd3) : (tap_r + 4'd1);
`else
            tap_nxt_s = tap_r + 4'd1;
`endif
        end else begin
            tap_nxt_s = first_tap_s;
        end
    end

    // Control FSM with registered outputs and window capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            tap_r       <= 4'd0;
            cap_k_r     <= 4'd0;
            cap_v_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= {ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_idx_r   <= {OIDX_W{1'b0}};
`ifdef CONV_REUSE_EN
            partial_r   <= 1'b0;
`endif
            for (int k = 0; k < FILTERSIZE; k++) win_r[k] <= 8'd0;
        end else begin
            // Read data returns one cycle after the strobe, tagged with its tap.
            cap_v_r   <= rd_en_r;
            cap_k_r   <= tap_r;
            if (cap_v_r) win_r[cap_k_r] <= rd_data;
            out_idx_r <= idx_nxt_s;
            done_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= FETCH;
                        busy_r    <= 1'b1;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= addr_nxt_s;
                        tap_r     <= tap_nxt_s;
`ifdef CONV_REUSE_EN
                        partial_r <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (tap_r == TAP_LAST) begin
                        state_r <= SETTLE;
                        rd_en_r <= 1'b0;
                    end else begin
                        rd_addr_r <= addr_nxt_s;
                        tap_r     <= tap_nxt_s;
                    end
                end
                SETTLE: state_r <= RELU;
                RELU: begin
                    state_r     <= EMIT;
                    out_valid_r <= 1'b1;
                end
                EMIT: begin
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                        if (last_win_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= FETCH;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= addr_nxt_s;
                            tap_r     <= tap_nxt_s;
`ifdef CONV_REUSE_EN
                            partial_r <= (first_tap_s == TAP_REUSE_FIRST);
                            if (first_tap_s == TAP_REUSE_FIRST) begin
                                for (int r = 0; r < KDIM; r++) begin
                                    win_r[KDIM*r]   <= win_r[KDIM*r+1];
                                    win_r[KDIM*r+1] <= win_r[KDIM*r+2];
                                end
                            end
`endif
                        end
                    end
                end
                DONE: state_r <= IDLE;
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    rd_en_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < FILTERSIZE; k++) begin : g_ifmap
        assign ifmap_o[8*k +: 8] = win_r[k];
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_en     = rd_en_r;
    assign rd_addr   = rd_addr_r;
    assign out_valid = out_valid_r;
    assign out_idx   = out_idx_r;
    assign out_data  = out_valid_r ? ofmap_i : 8'd0;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on a 5x5 map with a behavioural window model.
module tb_conv_window_ctrl;
    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NWIN = (W-2)*(H-2);
`ifdef CONV_REUSE_EN
    localparam int EXP_CYC = 2 + (H-2)*12 + (NWIN-(H-2))*6;
    localparam int EXP_RD  = (H-2)*9 + (NWIN-(H-2))*3;
`else
    localparam int EXP_CYC = NWIN*12 + 2;
    localparam int EXP_RD  = NWIN*9;
`endif
    localparam logic [71:0] FIRST_WIN = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] LAST_WIN  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en, out_valid;
    logic [9:0]  rd_addr, out_idx;
    logic [7:0]  rd_data = 8'd0;
    logic [7:0]  ofmap_i = 8'd0;
    logic [71:0] ifmap_o;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;

    logic [7:0]  mem [W*H];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    logic [71:0] first_seen, last_seen;

    conv_window_ctrl #(
        .IMG_W(W), .IMG_H(H), .FILTERSIZE(9), .ADDR_W(10), .OIDX_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .ifmap_o(ifmap_o),
        .ofmap_i(ofmap_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    // Stand-in for the conv datapath: any fixed function of the whole window.
    function automatic logic [7:0] conv_ref(input logic [71:0] w);
        logic [7:0] s;
        s = 8'd0;
        for (int k = 0; k < 9; k++) s = s + 8'(k + 1) * w[8*k +: 8];
        return s;
    endfunction

    function automatic logic [71:0] exp_win(input int n);
        logic [71:0] w;
        int r, c;
        r = n / (W-2);
        c = n % (W-2);
        for (int k = 0; k < 9; k++) w[8*k +: 8] = mem[(r + k/3)*W + c + k%3];
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[int'(rd_addr) % (W*H)];
        ofmap_i <= conv_ref(ifmap_o);
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < W*H; i++) mem[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < W*H; i++) mem[i] = 8'($urandom);
    endtask

    // mode 0: always ready, 1: random ready, 2: 7-cycle stall on window 3
    task automatic run_pass(input int mode, input bit inj_start);
        int cyc, n_out, stalls, stall_run, rd0, dn0;
        bit fin;
        logic [71:0] w_exp;
        rd0 = rd_cnt;
        dn0 = done_cnt;
        first_seen = '1;
        last_seen  = '1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 2;
        n_out = 0; stalls = 0; stall_run = 0; fin = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!fin && cyc < 3000) begin
            start = inj_start && (cyc == 30);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = !(out_valid && n_out == 3 && stall_run < 7);
            endcase
            if (out_valid) begin
                if (n_out < NWIN) begin
                    w_exp = exp_win(n_out);
                    chk("ifmap", ifmap_o, w_exp);
                    chk("out_data", out_data, conv_ref(w_exp));
                    chk("out_idx", out_idx, n_out);
                    chk("no_rd_in_emit", rd_en, 0);
                    if (n_out == 0) first_seen = ifmap_o;
                    if (n_out == NWIN-1) last_seen = ifmap_o;
                end else begin
                    chk("extra_output", n_out, NWIN-1);
                end
                if (out_ready) begin
                    n_out++;
                    stall_run = 0;
                end else begin
                    stalls++;
                    stall_run++;
                end
            end else begin
                chk("out_data_zero", out_data, 0);
            end
            if (done) begin
                fin = 1'b1;
                chk("done_cycle", cyc, EXP_CYC + stalls);
                chk("busy_low_at_done", busy, 0);
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", fin, 1);
        chk("n_out", n_out, NWIN);
        chk("rd_count", rd_cnt - rd0, EXP_RD);
        @(posedge clk);
        #1;
        chk("done_width", done, 0);
        chk("idle_busy", busy, 0);
        chk("done_count", done_cnt - dn0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("stays_idle", busy, 0);
    endtask

    task automatic run_abort();
        int vcnt, guard, dn0;
        dn0 = done_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vcnt = 0;
        guard = 0;
        while (vcnt < 4 && guard < 500) begin
            if (out_valid) vcnt++;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("abort_reach_w4", vcnt, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mid_fetch", rd_en, 1);
        chk("abort_idx", out_idx, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_rd_addr", rd_addr, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ifmap", ifmap_o, 0);
        chk("abort_idx0", out_idx, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - dn0, 0);
    endtask

    initial begin
        fill_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ifmap", ifmap_o, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_pass(0, 1'b0);
        chk("first_window", first_seen, FIRST_WIN);
        chk("last_window", last_seen, LAST_WIN);

        fill_random();
        run_pass(1, 1'b0);

        fill_random();
        run_pass(2, 1'b0);

        fill_identity();
        run_pass(0, 1'b1);

        run_abort();
        run_pass(0, 1'b0);
        chk("restart_first_window", first_seen, FIRST_WIN);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Sequencer for the 3x3 convolution datapath (`conv` unit: 9 mixer_pixel multipliers, average_conv, registered Relu).
- Walks a single-channel IMG_W x IMG_H 8-bit feature map stored in a synchronous-read buffer.
- Gathers each 3x3 window into the 72-bit ifmap bus and holds it stable while `conv` evaluates.
- Returns each Relu result over a valid/ready output stream tagged with its output index.
- Sits between the feature-map buffer and the next layer (pooling or output buffer).

Parameters:
- IMG_W, 28, input map width in pixels (>=3).
- IMG_H, 28, input map height in pixels (>=3).
- FILTERSIZE, 9, taps per window; fixed at 9 (3x3).
- ADDR_W, 10, read-address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- OIDX_W, 10, output-index width; must satisfy 2^OIDX_W >= (IMG_W-2)*(IMG_H-2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a full-map pass when idle.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last output handshake.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  pixel address = row*IMG_W + col.
- rd_data  in  8  pixel data, valid exactly 1 cycle after rd_en.
- ifmap_o  out  8*FILTERSIZE  window to conv.ifmap; byte k = tap (k/3, k%3), byte 0 = top-left.
- ofmap_i  in  8  conv.ofmap (registered Relu output).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- out_data  out  8  = ofmap_i while out_valid; 0 otherwise.
- out_idx  out  OIDX_W  = wr*(IMG_W-2) + wc for the current window.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, rd_en, out_valid = 0; rd_addr, ifmap_o, out_idx = 0; window counters wr, wc = 0; tap counter = 0.
- States:
  - IDLE: wait for start; on start go to FETCH, wr=wc=0. start is ignored in every state except IDLE.
  - FETCH: rd_en=1 for one cycle per tap, taps in order k=0..8. rd_addr = (wr+k/3)*IMG_W + (wc+k%3). Data for tap k is written into byte k of the window register on the following cycle. After issuing tap 8, go to SETTLE.
  - SETTLE: 1 cycle; rd_en=0; tap 8 data is captured; window complete at the end of this cycle.
  - RELU: 1 cycle; window held; the Relu register samples at the end of the cycle.
  - EMIT: out_valid=1; window held stable so ofmap_i stays constant.
    - On out_valid && out_ready: advance wc. At wc = IMG_W-3, wrap wc to 0 and increment wr.
    - If the last window (wr=IMG_H-3, wc=IMG_W-3) is accepted, go to DONE; otherwise go to FETCH.
    - out_valid, out_data and out_idx stay stable while out_ready=0; out_valid never drops without a handshake.
  - DONE: 1 cycle; done=1, busy=0 next; go to IDLE.
- Latency: with out_ready held 1, 12 cycles per window (9 FETCH + SETTLE + RELU + 1 EMIT). Full pass = (IMG_W-2)*(IMG_H-2)*12 + 2 cycles.
- Counter widths: rd_addr computed modulo 2^ADDR_W; counters never exceed IMG_W-3 or IMG_H-3.
- ifmap_o changes only during FETCH/SETTLE (capture) or on a shift (Optional Feature); never during RELU or EMIT.
- Reset mid-pass: immediate abort to the reset state; no done pulse; a later start restarts at window (0,0).

Optional Feature:
- Macro: CONV_REUSE_EN (column reuse).
- Defined: for wc>0, on entry to FETCH the window shifts left by one column (bytes 0<-1, 1<-2, 3<-4, 4<-5, 6<-7, 7<-8). Only taps 2, 5, 8 are fetched (3 FETCH cycles, same order). wc=0 still fetches all 9 taps. Per-window cost is 6 cycles for wc>0.
- Undefined: always fetch all 9 taps. Outputs are identical in both builds; only timing differs.

Decomposition:
- Shared package conv_ctrl_pkg: state enum (IDLE, FETCH, SETTLE, RELU, EMIT, DONE), FILTERSIZE=9, KDIM=3, tap-to-(row,col) lookup constants.
- Sub-module conv_addr_gen: combinational wr/wc/tap to rd_addr and out_idx, using multiply-free incremental row-base registers. It is instantiated once.

Test Plan:
- IMG_W=IMG_H=5; memory returns rd_data=addr[7:0]; out_ready=1; start -> first ifmap_o bytes 0..8 = {0,1,2,5,6,7,10,11,12}. Exactly 9 outputs, out_idx 0..8 in order. done occurs 110 cycles after start.
- Same map; check last window -> bytes = {12,13,14,17,18,19,22,23,24}, out_idx=8; rd_en high exactly 81 cycles in the pass.
- Backpressure: out_ready=0 for 7 cycles during window 3 -> out_valid, out_data and out_idx held; ifmap_o unchanged; no rd_en; resumes on ready.
- Reset: assert rst_n=0 mid-FETCH of window 4 -> all outputs 0 immediately, no done. A new start restarts at out_idx 0 with the first window {0,1,2,5,6,7,10,11,12}.
- start pulsed while busy -> ignored; output count still 9, one done pulse.
- CONV_REUSE_EN, 5x5 -> identical window/idx sequence to the first test. rd_en count = 3*9 + 6*3 = 45; pass completes in 2 + 3*12 + 6*6 = 74 cycles.
